// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the convolution front end.
//   DATA_WIDTH : bits per pixel
//   IMG_W/IMG_H: image geometry in pixels
//   K          : convolution window edge (window = K*K pixels)
//   pixel_t    : one pixel
//   window_t   : K*K pixels, element [r*K+c] with r/c = 0 at the top-left
// lastEmitIndex() gives the row/column index of the final pixel that produces
// a window, for either unit stride or stride 2.
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int IMG_W      = 32;
    localparam int IMG_H      = 32;
    localparam int K          = 5;

    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [K*K-1:0]      window_t;

    // Index of the last pixel (along one axis) whose window is emitted.
    function automatic int lastEmitIndex(input int extent, input bit stride2);
        int idx;
        if (stride2) begin
            idx = (K - 1) + ((extent - K) / 2) * 2;
        end else begin
            idx = extent - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_window_gen_line_buffer
// IMG_W-deep line store holding the K-1 previous rows of every column.
// Each word packs K-1 pixels: tap 0 is the row directly above the current
// pixel, tap K-2 is the oldest row.  Read is combinational so the taps for
// the current column are available in the same cycle the pixel is accepted
// (read-before-write); the write pushes the new pixel in as tap 0 and drops
// the oldest row.
// Ports:
//   clk     : rising-edge clock
//   wrEn    : pixel accepted this cycle, update column addr
//   addr    : current column
//   wrPixel : accepted pixel
//   taps    : (K-1)*DATA_WIDTH vertical taps for column addr
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module conv_window_gen_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH  = IMG_W,
    parameter int TAPS   = K - 1,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic                       clk,
    input  logic                       wrEn,
    input  logic [ADDR_W-1:0]          addr,
    input  pixel_t                     wrPixel,
    output logic [TAPS*DATA_WIDTH-1:0] taps
);

    logic [TAPS*DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [TAPS*DATA_WIDTH-1:0] wrWord_s;

    assign taps = mem_r[addr];

    generate
        if (TAPS > 1) begin : g_shift
            assign wrWord_s = {taps[(TAPS-1)*DATA_WIDTH-1:0], wrPixel};
        end else begin : g_single
            assign wrWord_s = wrPixel;
        end
    endgenerate

    // Column update: age the stored rows by one and insert the new pixel.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[addr] <= wrWord_s;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Streaming KxK sliding-window generator.  Pixels arrive one per beat in
// raster order; every pixel at row>=K-1, col>=K-1 completes a window that is
// presented one cycle later on out_window through a one-deep output register.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset (partial frame discarded)
//   in_valid   : in_pixel valid
//   in_ready   : pixel accepted when in_valid && in_ready
//   in_pixel   : raster-order pixel
//   out_valid  : out_window valid, held until out_ready
//   out_ready  : consumer takes the window
//   out_window : element [r*K+c] at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_last   : final window of the frame
//   frame_done : one-cycle pulse after the final window handshakes
// Build option: define CONV_WIN_STRIDE2_EN to emit only windows whose row and
// column offsets from K-1 are both even; out_last then marks the last window
// actually emitted.
// -----------------------------------------------------------------------------
module conv_window_gen
    import cnn_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_pixel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [K*K*DATA_WIDTH-1:0]      out_window,
    output logic                           out_last,
    output logic                           frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int TAPS  = K - 1;

`ifdef CONV_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif

    localparam logic [COL_W-1:0] FIRST_COL = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] MAX_COL   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] MAX_ROW   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(lastEmitIndex(IMG_W, STRIDE2));
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(lastEmitIndex(IMG_H, STRIDE2));

    logic [COL_W-1:0]          col_r;
    logic [ROW_W-1:0]          row_r;
    window_t                   winReg_r;
    window_t                   nextWin_s;
    logic [TAPS*DATA_WIDTH-1:0] lbTaps_s;

    logic                      inReady_s;
    logic                      inAccept_s;
    logic                      emit_s;
    logic                      isLast_s;
    logic                      outHandshake_s;

    logic                      outValid_r;
    window_t                   outWindow_r;
    logic                      outLast_r;
    logic                      frameDone_r;

    conv_window_gen_line_buffer u_line_buffer (
        .clk     (clk),
        .wrEn    (inAccept_s),
        .addr    (col_r),
        .wrPixel (in_pixel),
        .taps    (lbTaps_s)
    );

    // Handshake and window-emission decode for the pixel on the input.
    always_comb begin
        inReady_s      = !outValid_r || out_ready;
        inAccept_s     = in_valid && inReady_s;
        outHandshake_s = outValid_r && out_ready;
        emit_s         = 1'b0;
        isLast_s       = (row_r == LAST_ROW) && (col_r == LAST_COL);
        if ((row_r >= FIRST_ROW) && (col_r >= FIRST_COL)) begin
`ifdef CONV_WIN_STRIDE2_EN
            // (x - (K-1)) is even exactly when x and K-1 share the LSB.
            emit_s = (row_r[0] == FIRST_ROW[0]) && (col_r[0] == FIRST_COL[0]);
`else
            emit_s = 1'b1;
`endif
        end else begin
            emit_s = 1'b0;
        end
    end

    // Next window: shift every row left one column, new column enters at K-1
    // built from the line-buffer taps (oldest row on top) plus the new pixel.
    always_comb begin
        nextWin_s = winReg_r;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                nextWin_s[r*K + c] = winReg_r[r*K + c + 1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            nextWin_s[r*K + K - 1] = lbTaps_s[(K-2-r)*DATA_WIDTH +: DATA_WIDTH];
        end
        nextWin_s[(K-1)*K + K - 1] = in_pixel;
    end

    // Raster position of the next pixel; wraps to (0,0) after the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (inAccept_s) begin
            if (col_r == MAX_COL) begin
                col_r <= '0;
                if (row_r == MAX_ROW) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // KxK window shift register; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (inAccept_s) begin
            winReg_r <= nextWin_s;
        end else begin
            winReg_r <= winReg_r;
        end
    end

    // Output register: loads a fresh window (possibly while the previous one
    // drains in the same cycle), otherwise holds until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid_r  <= 1'b0;
            outWindow_r <= '0;
            outLast_r   <= 1'b0;
        end else if (inAccept_s && emit_s) begin
            outValid_r  <= 1'b1;
            outWindow_r <= nextWin_s;
            outLast_r   <= isLast_s;
        end else if (outHandshake_s) begin
            outValid_r  <= 1'b0;
            outWindow_r <= outWindow_r;
            outLast_r   <= 1'b0;
        end else begin
            outValid_r  <= outValid_r;
            outWindow_r <= outWindow_r;
            outLast_r   <= outLast_r;
        end
    end

    // End-of-frame pulse, one cycle after the final window is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameDone_r <= 1'b0;
        end else begin
            frameDone_r <= outHandshake_s && outLast_r;
        end
    end

    assign in_ready   = inReady_s;
    assign out_valid  = outValid_r;
    assign out_window = outWindow_r;
    assign out_last   = outLast_r;
    assign frame_done = frameDone_r;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
// Scoreboard bench: the driver pushes the expected window for every accepted
// pixel that completes one; a negedge monitor pops and compares on each
// output handshake, and also checks hold-while-stalled, out_last, per-frame
// window count and the frame_done pulse.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;
    import cnn_pkg::*;

`ifdef CONV_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
    localparam int EXP_WIN = 196;
    localparam int LAST_R  = 30;
    localparam int LAST_C  = 30;
`else
    localparam bit STRIDE2 = 1'b0;
    localparam int EXP_WIN = 784;
    localparam int LAST_R  = 31;
    localparam int LAST_C  = 31;
`endif

    typedef struct {
        window_t win;
        logic    last;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_pixel = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [K*K*DATA_WIDTH-1:0] out_window;
    logic                      out_last;
    logic                      frame_done;

    exp_t    expQ[$];
    int      tests = 0;
    int      fails = 0;
    int      rdyMode = 0;
    int      windowsSeen = 0;
    logic    doneNext = 1'b0;
    logic    prevStall = 1'b0;
    window_t heldWin;
    logic    heldLast;

    conv_window_gen dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic pixel_t pixVal(input int base, input int r, input int c);
        return pixel_t'(base + r * IMG_W + c);
    endfunction

    // Consumer: out_ready pattern changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(0, 99) < 70);
        endcase
    end

    task automatic check(input string name, input logic [K*K*DATA_WIDTH-1:0] act,
                         input logic [K*K*DATA_WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: all output checks happen on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            windowsSeen = 0;
            doneNext    = 1'b0;
            prevStall   = 1'b0;
        end else begin
            if (doneNext || frame_done) begin
                check("frame_done", {{(K*K*DATA_WIDTH-1){1'b0}}, frame_done},
                      {{(K*K*DATA_WIDTH-1){1'b0}}, doneNext});
            end
            doneNext = 1'b0;
            if (prevStall) begin
                check("hold_valid", {{(K*K*DATA_WIDTH-1){1'b0}}, out_valid}, 1);
                check("hold_window", out_window, heldWin);
                check("hold_last", {{(K*K*DATA_WIDTH-1){1'b0}}, out_last},
                      {{(K*K*DATA_WIDTH-1){1'b0}}, heldLast});
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_window: got %h expected none", out_window);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("window", out_window, e.win);
                    check("out_last", {{(K*K*DATA_WIDTH-1){1'b0}}, out_last},
                          {{(K*K*DATA_WIDTH-1){1'b0}}, e.last});
                end
                windowsSeen++;
                if (out_last) begin
                    check("frame_count", windowsSeen, EXP_WIN);
                    windowsSeen = 0;
                    doneNext    = 1'b1;
                end
            end
            prevStall = out_valid && !out_ready;
            heldWin   = out_window;
            heldLast  = out_last;
        end
    end

    task automatic push_expected(input int base, input int r, input int c);
        exp_t e;
        bit   emit;
        emit = (r >= K - 1) && (c >= K - 1);
        if (STRIDE2) emit = emit && (((r - (K - 1)) % 2) == 0) && (((c - (K - 1)) % 2) == 0);
        if (emit) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.win[i*K + j] = pixVal(base, r - (K - 1) + i, c - (K - 1) + j);
            e.last = (r == LAST_R) && (c == LAST_C);
            expQ.push_back(e);
        end
    endtask

    // Drive nPix pixels of a frame starting at (0,0); idlePct inserts gaps.
    task automatic send_frame(input int base, input int nPix, input int idlePct);
        for (int p = 0; p < nPix; p++) begin
            int r;
            int c;
            int guard;
            r = p / IMG_W;
            c = p % IMG_W;
            @(posedge clk);
            #1;
            guard = 0;
            while (idlePct > 0 && guard < 5 && $urandom_range(0, 99) < idlePct) begin
                in_valid = 1'b0;
                guard++;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_pixel = pixVal(base, r, c);
            @(negedge clk);
            guard = 0;
            while (!in_ready && guard < 1000) begin
                guard++;
                @(negedge clk);
            end
            if (!in_ready) begin
                tests++;
                fails++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at pixel %0d", p);
            end else begin
                push_expected(base, r, c);
            end
        end
    endtask

    task automatic stop_input();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (expQ.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", expQ.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", {{(K*K*DATA_WIDTH-1){1'b0}}, out_valid}, 0);
        check("rst_in_ready", {{(K*K*DATA_WIDTH-1){1'b0}}, in_ready}, 1);
        check("rst_out_last", {{(K*K*DATA_WIDTH-1){1'b0}}, out_last}, 0);
        check("rst_frame_done", {{(K*K*DATA_WIDTH-1){1'b0}}, frame_done}, 0);
    endtask

    initial begin
        #12;
        check_reset_state();
        @(negedge clk);
        reset = 1'b1;

        // 1: continuous stream, consumer always ready
        rdyMode = 0;
        send_frame(0, IMG_W * IMG_H, 0);
        stop_input();
        drain();

        // 2: consumer ready every other cycle
        rdyMode = 1;
        send_frame(0, IMG_W * IMG_H, 0);
        stop_input();
        drain();

        // 3: two frames back to back, second offset by 1000
        rdyMode = 0;
        send_frame(0, IMG_W * IMG_H, 0);
        send_frame(1000, IMG_W * IMG_H, 0);
        stop_input();
        drain();

        // 4: reset after 100 pixels, then a full frame
        send_frame(0, 100, 0);
        stop_input();
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        #2;
        check_reset_state();
        @(negedge clk);
        reset = 1'b1;
        send_frame(0, IMG_W * IMG_H, 0);
        stop_input();
        drain();

        // 5: random input gaps and random consumer stalls
        rdyMode = 2;
        send_frame(500, IMG_W * IMG_H, 30);
        stop_input();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
